data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single data-memory port (DataBusControl) between two requesters: port 0 is the RISCuin core load/store path, port 1 is the program loader / debug master.
- Sequences every access through a small FSM with a parameterised number of memory wait states.
- Detects misaligned accesses before they reach the bus and answers them with an error response.
- Drives a stall to the core so the program counter holds until the core's own access completes.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- DATA_WIDTH, 32, data width (equals INTERNAL_DATA_WIDTH).
- WAIT_STATES, 0, extra bus cycles held per access (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req0 / req1  in  1  access request, core / loader.
- we0 / we1  in  1  1 = write, 0 = read.
- size0 / size1  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- addr0 / addr1  in  ADDR_WIDTH  byte address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack; misaligned or illegal size.
- rdata  out  DATA_WIDTH  read data, valid with ack0 or ack1.
- core_stall  out  1  = req0 & ~ack0, combinational.
- bus_r / bus_w  out  1  read / write strobe to DataBusControl.
- bus_size  out  2  latched size.
- bus_addr  out  ADDR_WIDTH  latched address.
- bus_wdata  out  DATA_WIDTH  latched write data.
- bus_rdata  in  DATA_WIDTH  data from DataBusControl.

Behaviour:
- Reset (rst = 0), asynchronous:
  - state = IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All strobes, acks and errs = 0; bus_addr, bus_wdata, rdata = 0; bus_size = 00.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, pick the grantee. Single requester: that port. Both: the port != last_grant.
  - Latch id, we, size, addr and wdata.
  - Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0, or size = 11) -> RESP with err; no bus strobe is issued.
  - Otherwise -> BUSY with cnt = WAIT_STATES.
- BUSY:
  - bus_r = ~we_l and bus_w = we_l, both held every BUSY cycle; bus_addr, bus_size and bus_wdata are driven from the latches.
  - cnt == 0 -> capture bus_rdata into rdata (reads only), go to RESP.
  - Otherwise cnt decrements.
- RESP:
  - ack of the latched id = 1 and err = error flag for exactly one cycle; last_grant = id.
  - Next state is always IDLE. No new grant is made in RESP.
- Outside BUSY: strobes are 0; bus_addr and bus_wdata return to 0.
- Latency (req sampled high at edge E0):
  - Aligned access: ack during cycle E0 + WAIT_STATES + 2.
  - Misaligned access: ack during cycle E0 + 1.
  - Throughput: one access per WAIT_STATES + 3 cycles.
- Handshake:
  - A requester holds req and its operands stable until ack.
  - req still high in the IDLE cycle after ack is treated as a new request.
  - req dropped mid-BUSY does not abort: the access completes and ack is still pulsed.
- Fairness: with both ports requesting continuously, grants strictly alternate.
- rdata: holds its last value between acks; it is unchanged on writes and on errors.
- Reset mid-BUSY: strobes fall immediately (asynchronously); no ack is issued.
- cnt width: $clog2(WAIT_STATES+1), minimum 1.

Decomposition:
- Shared header DataBus.vh: size codes BUS_BYTE, BUS_HALF, BUS_WORD; requester ids REQ_CORE = 0, REQ_LOADER = 1.
- State encoding stays local to the module.
- One sub-module, rr_arbiter2: a combinational two-way round-robin pick from (req0, req1, last_grant), producing gnt_id and gnt_valid.

Test Plan:
- WAIT_STATES = 0, core word read at addr 0x10, bus_rdata = 0xDEADBEEF -> bus_r high 1 cycle; ack0 in cycle 2 with rdata = 0xDEADBEEF, err0 = 0; core_stall high cycles 0-1, low in cycle 2.
- req0 and req1 raised together, held after each ack -> grant order 0, 1, 0, 1; never two consecutive grants to one port.
- Core half read at addr 0x13 -> no bus_r pulse; ack0 = 1 and err0 = 1 in cycle 1; rdata unchanged.
- WAIT_STATES = 3, loader byte write addr 0x21 data 0x5A -> bus_w high 4 cycles with bus_addr = 0x21, bus_size = 00, bus_wdata = 0x5A; ack1 in cycle 5.
- rst driven low in the second BUSY cycle (WAIT_STATES = 3) -> bus_w falls the same instant, no ack; after release, a new core request is granted first.
- size = 11 on the loader -> err1 = 1 with ack1, no strobe.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: bus size codes,
// requester ids and the alignment rule applied before any bus access.
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_BYTE = 2'b00,
        BUS_HALF = 2'b01,
        BUS_WORD = 2'b10,
        BUS_RSVD = 2'b11
    } bus_size_e;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    // Reserved size code is reported the same way as a misaligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            BUS_BYTE: return 1'b0;
            BUS_HALF: return addr_lo[0];
            BUS_WORD: return addr_lo != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester handshakes plus the DataBusControl port, shared by the arbiter
// (slave side) and whatever drives requests and models memory (master side).
interface data_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [1:0]            size0, size1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  ack0, ack1;
    logic                  err0, err1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  core_stall;
    logic                  bus_r, bus_w;
    logic [1:0]            bus_size;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata, core_stall,
        output bus_r, bus_w, bus_size, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata, core_stall,
        input  bus_r, bus_w, bus_size, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// port that was not granted last.
module rr_arbiter2
    import data_bus_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_id,
    output logic gnt_valid
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) gnt_id = ~last_grant;
        else if (req1)    gnt_id = REQ_LOADER;
        else              gnt_id = REQ_CORE;
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the DataBusControl port between the core (port 0) and the loader
// (port 1); one access at a time through IDLE -> BUSY -> RESP.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input logic               clk,
    input logic               rst,
    data_bus_arbiter_if.slave bif
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  gnt_id, gnt_valid;
    logic                  busy, ack0, ack1;

    rr_arbiter2 u_rr (
        .req0       (bif.req0),
        .req1       (bif.req1),
        .last_grant (last_grant_q),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        err_d        = err_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    we_d    = gnt_id ? bif.we1    : bif.we0;
                    size_d  = gnt_id ? bif.size1  : bif.size0;
                    addr_d  = gnt_id ? bif.addr1  : bif.addr0;
                    wdata_d = gnt_id ? bif.wdata1 : bif.wdata0;
                    err_d   = is_misaligned(size_d, addr_d[1:0]);
                    cnt_d   = CNT_INIT;
                    // Faulting accesses skip the bus entirely.
                    state_d = err_d ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (!we_q) rdata_d = bif.bus_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                last_grant_d = id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_LOADER;
            id_q         <= REQ_CORE;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            err_q        <= err_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign ack0 = (state_q == RESP) && (id_q == REQ_CORE);
    assign ack1 = (state_q == RESP) && (id_q == REQ_LOADER);

    assign bif.ack0       = ack0;
    assign bif.ack1       = ack1;
    assign bif.err0       = ack0 & err_q;
    assign bif.err1       = ack1 & err_q;
    assign bif.rdata      = rdata_q;
    assign bif.core_stall = bif.req0 & ~ack0;
    assign bif.bus_r      = busy & ~we_q;
    assign bif.bus_w      = busy & we_q;
    assign bif.bus_size   = size_q;
    assign bif.bus_addr   = busy ? addr_q  : '0;
    assign bif.bus_wdata  = busy ? wdata_q : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: one instance with no wait states, one with three,
// driven by directed accesses and checked through a per-instance response queue.
module tb_data_bus_arbiter;
    import data_bus_arbiter_pkg::*;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sbq0[$];
    exp_t sbq3[$];
    logic [31:0] mdl_rd [2];

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bi0 ();
    data_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bi3 ();

    data_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bif(bi0));
    data_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .bif(bi3));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic get_ack(input bit d, input bit p);
        if (d) return p ? bi3.ack1 : bi3.ack0;
        return p ? bi0.ack1 : bi0.ack0;
    endfunction
    function automatic logic get_r(input bit d);            return d ? bi3.bus_r : bi0.bus_r; endfunction
    function automatic logic get_w(input bit d);            return d ? bi3.bus_w : bi0.bus_w; endfunction
    function automatic logic get_stall(input bit d);        return d ? bi3.core_stall : bi0.core_stall; endfunction
    function automatic logic [1:0] get_size(input bit d);   return d ? bi3.bus_size : bi0.bus_size; endfunction
    function automatic logic [31:0] get_addr(input bit d);  return d ? bi3.bus_addr : bi0.bus_addr; endfunction
    function automatic logic [31:0] get_wdata(input bit d); return d ? bi3.bus_wdata : bi0.bus_wdata; endfunction

    task automatic set_rdata(input bit d, input logic [31:0] v);
        if (d) bi3.bus_rdata = v; else bi0.bus_rdata = v;
    endtask

    task automatic drive(input bit d, input bit p, input bit r, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (!d && !p) begin bi0.req0 = r; bi0.we0 = we; bi0.size0 = sz; bi0.addr0 = a; bi0.wdata0 = wd; end
        if (!d &&  p) begin bi0.req1 = r; bi0.we1 = we; bi0.size1 = sz; bi0.addr1 = a; bi0.wdata1 = wd; end
        if ( d && !p) begin bi3.req0 = r; bi3.we0 = we; bi3.size0 = sz; bi3.addr0 = a; bi3.wdata0 = wd; end
        if ( d &&  p) begin bi3.req1 = r; bi3.we1 = we; bi3.size1 = sz; bi3.addr1 = a; bi3.wdata1 = wd; end
    endtask

    // Expected response: reads that complete return bus data, anything else keeps rdata.
    task automatic push_exp(input bit d, input bit id, input bit err, input bit we, input logic [31:0] rd);
        exp_t e;
        e.id    = id;
        e.err   = err;
        e.rdata = (!err && !we) ? rd : mdl_rd[d];
        mdl_rd[d] = e.rdata;
        if (d) sbq3.push_back(e); else sbq0.push_back(e);
    endtask

    task automatic sb_pop(input bit d, input bit id, input bit err, input logic [31:0] rd);
        exp_t e;
        string pfx = d ? "sb3" : "sb0";
        if ((d ? sbq3.size() : sbq0.size()) == 0) begin
            check({pfx, "_spurious_ack"}, 0, 1);
            return;
        end
        if (d) e = sbq3.pop_front(); else e = sbq0.pop_front();
        check({pfx, "_id"}, id, e.id);
        check({pfx, "_err"}, err, e.err);
        check({pfx, "_rdata"}, rd, e.rdata);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bi0.ack0 || bi0.ack1) begin
                check("sb0_dual_ack", bi0.ack0 & bi0.ack1, 0);
                sb_pop(0, bi0.ack1, bi0.err0 | bi0.err1, bi0.rdata);
            end
            if (bi3.ack0 || bi3.ack1) begin
                check("sb3_dual_ack", bi3.ack0 & bi3.ack1, 0);
                sb_pop(1, bi3.ack1, bi3.err0 | bi3.err1, bi3.rdata);
            end
        end
    end

    // Single access from port p; starts #1 after a rising edge with the DUT idle.
    task automatic acc(input bit d, input bit p, input bit we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input bit exp_err, input int drop_at, input string tag);
        int ws      = d ? 3 : 0;
        int exp_lat = exp_err ? 1 : ws + 2;
        int exp_str = exp_err ? 0 : ws + 1;
        int n_str   = 0;
        int lat     = -1;
        push_exp(d, p, exp_err, we, rd);
        set_rdata(d, rd);
        drive(d, p, 1'b1, we, sz, a, wd);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (get_r(d) || get_w(d)) begin
                n_str++;
                check({tag, "_bus_w"}, get_w(d), we);
                check({tag, "_bus_r"}, get_r(d), !we);
                check({tag, "_bus_addr"}, get_addr(d), a);
                check({tag, "_bus_size"}, get_size(d), sz);
                check({tag, "_bus_wdata"}, get_wdata(d), wd);
            end
            if (!p) check({tag, "_stall"}, get_stall(d),
                          (n < exp_lat) && !(drop_at >= 0 && n > drop_at));
            if (get_ack(d, p)) begin
                lat = n;
                check({tag, "_idle_addr"}, get_addr(d), 0);
                check({tag, "_idle_wdata"}, get_wdata(d), 0);
                break;
            end
            if (n == drop_at) drive(d, p, 1'b0, we, sz, a, wd);
            @(posedge clk); #1;
        end
        drive(d, p, 1'b0, we, sz, a, wd);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_strobes"}, n_str, exp_str);
        @(posedge clk); #1;
    endtask

    // Both ports request continuously; grants must alternate starting at 'first'.
    task automatic both_req(input bit d, input bit first, input int count, input string tag);
        int ws = d ? 3 : 0;
        int k  = 0;
        for (int i = 0; i < count; i++) begin
            bit id = first ^ i[0];
            push_exp(d, id, 1'b0, id, 32'h1234_5678);
        end
        set_rdata(d, 32'h1234_5678);
        drive(d, 1'b0, 1'b1, 1'b0, BUS_WORD, 32'h40, 32'h0);
        drive(d, 1'b1, 1'b1, 1'b1, BUS_WORD, 32'h44, 32'hCAFE_F00D);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (get_ack(d, 1'b0) || get_ack(d, 1'b1)) begin
                check({tag, "_ack_cycle"}, n, ws + 2 + k * (ws + 3));
                k++;
                if (k == count) break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_grants"}, k, count);
        drive(d, 1'b0, 1'b0, 1'b0, BUS_WORD, 32'h40, 32'h0);
        drive(d, 1'b1, 1'b0, 1'b1, BUS_WORD, 32'h44, 32'hCAFE_F00D);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        for (int d = 0; d < 2; d++) begin
            drive(d[0], 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            drive(d[0], 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            set_rdata(d[0], 32'h0);
        end
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl0", {bi0.ack0, bi0.ack1, bi0.err0, bi0.err1, bi0.bus_r, bi0.bus_w,
                           bi0.bus_size, bi0.core_stall}, 0);
        check("rst_addr0", bi0.bus_addr, 0);
        check("rst_wdata0", bi0.bus_wdata, 0);
        check("rst_rdata0", bi0.rdata, 0);
        check("rst_ctl3", {bi3.ack0, bi3.ack1, bi3.bus_r, bi3.bus_w, bi3.bus_size}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        acc(1'b0, 1'b0, 1'b0, BUS_WORD, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, -1, "core_rd_word");
        acc(1'b0, 1'b1, 1'b0, BUS_RSVD, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b1, -1, "ld_size11");
        both_req(1'b0, 1'b0, 4, "fair0");
        acc(1'b0, 1'b0, 1'b0, BUS_HALF, 32'h13, 32'h0, 32'hFFFF_FFFF, 1'b1, -1, "core_half_mis");
        acc(1'b0, 1'b0, 1'b0, BUS_BYTE, 32'h13, 32'h0, 32'h0000_00A5, 1'b0, -1, "core_byte_odd");
        acc(1'b0, 1'b1, 1'b1, BUS_WORD, 32'h22, 32'h7777, 32'h0, 1'b1, -1, "ld_word_mis");
        acc(1'b0, 1'b1, 1'b0, BUS_HALF, 32'h26, 32'h0, 32'h0000_BEEF, 1'b0, -1, "ld_half_rd");
        acc(1'b1, 1'b1, 1'b1, BUS_BYTE, 32'h21, 32'h5A, 32'h0, 1'b0, -1, "ld_byte_wr3");
        acc(1'b1, 1'b0, 1'b0, BUS_WORD, 32'h100, 32'h0, 32'h55AA_55AA, 1'b0, 2, "core_drop3");

        // Reset asserted in the second BUSY cycle of a loader write.
        drive(1'b1, 1'b1, 1'b1, 1'b1, BUS_WORD, 32'h30, 32'h1122_3344);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstb_pre_bus_w", bi3.bus_w, 1);
        #2 rst = 1'b0;
        #1;
        check("rstb_bus_w", bi3.bus_w, 0);
        check("rstb_bus_addr", bi3.bus_addr, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, BUS_WORD, 32'h30, 32'h1122_3344);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rstb_no_ack", {bi3.ack0, bi3.ack1}, 0);
        end
        check("rstb_rdata0", bi0.rdata, 0);
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        both_req(1'b1, 1'b0, 2, "post_rst");

        check("sb0_left", sbq0.size(), 0);
        check("sb3_left", sbq3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
